// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead adder checker.
//   state_t    : checker run state (IDLE, RUN, DRAIN, DONE)
//   cnt_width  : width of vec_count/err_count for a given operand width
//   res_width  : width of an adder result {cout,sum} for a given operand width
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Counters are wide enough to count every {a,b,cin} vector without saturating.
    function automatic int unsigned cnt_width(input int unsigned width);
        return 2 * width + 2;
    endfunction

    // Result carries the carry-out above the sum bits.
    function automatic int unsigned res_width(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/cla_ref_model.sv
// Golden adder used to produce the expected response of the adder under check.
// Ports:
//   a, b : WIDTH-bit operands
//   cin  : carry-in
//   exp  : {cout,sum} expected result, WIDTH+1 bits
module cla_ref_model
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            b,
    input  logic                        cin,
    output logic [res_width(WIDTH)-1:0] exp
);

    localparam int unsigned RES_W = res_width(WIDTH);

    // Zero-extend all terms so the carry lands in the top bit.
    always_comb begin
        exp = RES_W'(a) + RES_W'(b) + RES_W'(cin);
    end

endmodule

// File: rtl/cla_checker.sv
// Run-based checker for a WIDTH-bit adder. A start pulse opens a run; every
// accepted vector is registered once, compared against the reference adder
// one edge later, and counted. The vector flagged with last closes the run.
// Optional feature (macro CLA_CHECKER_FIRST_FAIL_EN): capture the stimulus,
// response and expected value of the first mismatch of a run into ff_*.
// Without the macro the ff_* ports are tied to zero.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : one-cycle pulse, begins a run from IDLE or DONE
//   in_valid, in_ready  : vector handshake (in_ready high only in RUN)
//   a, b, cin           : stimulus applied to the adder under check
//   sum, cout           : response of the adder under check
//   last                : marks the final vector of the run
//   busy, done, pass    : run status
//   vec_count, err_count: vectors compared / mismatches (saturating)
//   ff_a, ff_b, ff_cin  : stimulus of the first mismatch
//   ff_got, ff_exp      : {cout,sum} observed and expected at the first mismatch
module cla_checker
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            b,
    input  logic                        cin,
    input  logic [WIDTH-1:0]            sum,
    input  logic                        cout,
    input  logic                        last,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [cnt_width(WIDTH)-1:0] vec_count,
    output logic [cnt_width(WIDTH)-1:0] err_count,
    output logic [WIDTH-1:0]            ff_a,
    output logic [WIDTH-1:0]            ff_b,
    output logic                        ff_cin,
    output logic [res_width(WIDTH)-1:0] ff_got,
    output logic [res_width(WIDTH)-1:0] ff_exp
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned RES_W = res_width(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               run_clear;

    logic               pipe_valid;
    logic [WIDTH-1:0]   pipe_a;
    logic [WIDTH-1:0]   pipe_b;
    logic               pipe_cin;
    logic [RES_W-1:0]   pipe_got;
    logic [RES_W-1:0]   exp_res;
    logic               mismatch;

    // Vectors are only taken while a run is open; start never doubles as a vector.
    assign accept = in_valid && (state == RUN);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; run_clear marks the edge that opens a fresh run.
    always_comb begin
        state_nxt = state;
        run_clear = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                    run_clear = 1'b1;
                end
            end
            RUN: begin
                if (accept && last) begin
                    state_nxt = DRAIN;
                end
            end
            // The final vector sits in the pipeline stage; its compare commits
            // on this same edge, so DONE always reports final counts.
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    run_clear = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Single pipeline stage holding the accepted vector and its response.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= 1'b0;
            pipe_a     <= '0;
            pipe_b     <= '0;
            pipe_cin   <= 1'b0;
            pipe_got   <= '0;
        end else begin
            pipe_valid <= accept;
            if (accept) begin
                pipe_a   <= a;
                pipe_b   <= b;
                pipe_cin <= cin;
                pipe_got <= {cout, sum};
            end
        end
    end

    cla_ref_model #(
        .WIDTH (WIDTH)
    ) u_ref (
        .a   (pipe_a),
        .b   (pipe_b),
        .cin (pipe_cin),
        .exp (exp_res)
    );

    assign mismatch = pipe_valid && (exp_res != pipe_got);

    // Saturating vector and error counters.
    always_ff @(posedge clk) begin
        if (rst || run_clear) begin
            vec_count <= '0;
            err_count <= '0;
        end else if (pipe_valid) begin
            if (vec_count != {CNT_W{1'b1}}) begin
                vec_count <= vec_count + CNT_W'(1);
            end
            if (mismatch && (err_count != {CNT_W{1'b1}})) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

    // Status is decoded straight from the state register.
    assign in_ready = (state == RUN);
    assign busy     = (state == RUN) || (state == DRAIN);
    assign done     = (state == DONE);
    assign pass     = done && (err_count == '0);

`ifdef CLA_CHECKER_FIRST_FAIL_EN
    logic captured;

    // First-failure capture; held until the next run opens or reset.
    always_ff @(posedge clk) begin
        if (rst || run_clear) begin
            captured <= 1'b0;
            ff_a     <= '0;
            ff_b     <= '0;
            ff_cin   <= 1'b0;
            ff_got   <= '0;
            ff_exp   <= '0;
        end else if (mismatch && !captured) begin
            captured <= 1'b1;
            ff_a     <= pipe_a;
            ff_b     <= pipe_b;
            ff_cin   <= pipe_cin;
            ff_got   <= pipe_got;
            ff_exp   <= exp_res;
        end
    end
`else
    assign ff_a   = '0;
    assign ff_b   = '0;
    assign ff_cin = 1'b0;
    assign ff_got = '0;
    assign ff_exp = '0;
`endif

endmodule

// File: tb/tb_cla_checker.sv
// Directed self-checking bench for cla_checker at WIDTH=4.
// Honours CLA_CHECKER_FIRST_FAIL_EN for the expected ff_* values.
module tb_cla_checker;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 2 * WIDTH + 2;
    localparam int unsigned RES_W = WIDTH + 1;
`ifdef CLA_CHECKER_FIRST_FAIL_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             last;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] vec_count;
    logic [CNT_W-1:0] err_count;
    logic [WIDTH-1:0] ff_a;
    logic [WIDTH-1:0] ff_b;
    logic             ff_cin;
    logic [RES_W-1:0] ff_got;
    logic [RES_W-1:0] ff_exp;

    int tests_run    = 0;
    int tests_failed = 0;

    cla_checker #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .last      (last),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .vec_count (vec_count),
        .err_count (err_count),
        .ff_a      (ff_a),
        .ff_b      (ff_b),
        .ff_cin    (ff_cin),
        .ff_got    (ff_got),
        .ff_exp    (ff_exp)
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are changed and outputs read 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_vec(input logic [3:0] va, input logic [3:0] vb, input logic vcin,
                             input logic [4:0] resp, input logic vlast);
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        cin      = vcin;
        {cout, sum} = resp;
        last     = vlast;
    endtask

    task automatic quiet();
        start    = 1'b0;
        in_valid = 1'b0;
        last     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        quiet();
        a = '0; b = '0; cin = 1'b0; sum = '0; cout = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tests_run++;
        if ({in_ready, busy, done, pass} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_status got=%b want=0000", {in_ready, busy, done, pass});
        end
        tests_run++;
        if (vec_count !== '0 || err_count !== '0) begin
            tests_failed++;
            $display("FAIL reset_counts got vec=%0d err=%0d want 0 0", vec_count, err_count);
        end
        tests_run++;
        if (ff_a !== '0 || ff_b !== '0 || ff_cin !== 1'b0 || ff_got !== '0 || ff_exp !== '0) begin
            tests_failed++;
            $display("FAIL reset_ff got a=%h b=%h cin=%b got=%h exp=%h want all 0",
                     ff_a, ff_b, ff_cin, ff_got, ff_exp);
        end
    endtask

    task automatic test_exhaustive();
        pulse_start();
        tests_run++;
        if ({in_ready, busy, done} !== 3'b110 || vec_count !== '0) begin
            tests_failed++;
            $display("FAIL start_run got rdy/busy/done=%b vec=%0d want 110 0",
                     {in_ready, busy, done}, vec_count);
        end
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            logic [4:0] r;
            v = 9'(i);
            r = 5'(v[8:5]) + 5'(v[4:1]) + 5'(v[0]);
            drive_vec(v[8:5], v[4:1], v[0], r, i == 511);
            tick();
            if (i == 511) begin
                tests_run++;
                if ({busy, done, in_ready} !== 3'b100) begin
                    tests_failed++;
                    $display("FAIL drain_status got busy/done/rdy=%b want 100", {busy, done, in_ready});
                end
            end
        end
        quiet();
        tick();
        tests_run++;
        if ({busy, done, pass} !== 3'b011) begin
            tests_failed++;
            $display("FAIL exh_status got busy/done/pass=%b want 011", {busy, done, pass});
        end
        tests_run++;
        if (vec_count !== CNT_W'(512) || err_count !== '0) begin
            tests_failed++;
            $display("FAIL exh_counts got vec=%0d err=%0d want 512 0", vec_count, err_count);
        end
    endtask

    task automatic test_single_error();
        pulse_start();
        drive_vec(4'h7, 4'h9, 1'b1, 5'h10, 1'b1);
        tick();
        quiet();
        tick();
        tests_run++;
        if (err_count !== CNT_W'(1) || vec_count !== CNT_W'(1) || pass !== 1'b0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_err got err=%0d vec=%0d pass=%b done=%b want 1 1 0 1",
                     err_count, vec_count, pass, done);
        end
        tests_run++;
        if (ff_exp !== (FF_EN ? 5'h11 : 5'h00) || ff_got !== (FF_EN ? 5'h10 : 5'h00)) begin
            tests_failed++;
            $display("FAIL single_ff_res got exp=%h got=%h", ff_exp, ff_got);
        end
        tests_run++;
        if (ff_a !== (FF_EN ? 4'h7 : 4'h0) || ff_b !== (FF_EN ? 4'h9 : 4'h0) || ff_cin !== FF_EN) begin
            tests_failed++;
            $display("FAIL single_ff_stim got a=%h b=%h cin=%b", ff_a, ff_b, ff_cin);
        end
    endtask

    task automatic test_two_errors();
        pulse_start();
        drive_vec(4'h3, 4'h4, 1'b0, 5'h00, 1'b0);
        tick();
        drive_vec(4'h1, 4'h1, 1'b0, 5'h02, 1'b0);
        start = 1'b1;                 // ignored while running
        tick();
        start = 1'b0;
        drive_vec(4'h5, 4'h6, 1'b0, 5'h1f, 1'b1);
        tick();
        quiet();
        tick();
        tests_run++;
        if (err_count !== CNT_W'(2) || vec_count !== CNT_W'(3) || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL two_err_counts got err=%0d vec=%0d done=%b want 2 3 1",
                     err_count, vec_count, done);
        end
        tests_run++;
        if (ff_a !== (FF_EN ? 4'h3 : 4'h0) || ff_b !== (FF_EN ? 4'h4 : 4'h0)
            || ff_exp !== (FF_EN ? 5'h07 : 5'h00)) begin
            tests_failed++;
            $display("FAIL two_err_ff got a=%h b=%h exp=%h", ff_a, ff_b, ff_exp);
        end
    endtask

    task automatic test_restart_in_done();
        pulse_start();
        tests_run++;
        if (vec_count !== '0 || err_count !== '0 || busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL restart got vec=%0d err=%0d busy=%b rdy=%b done=%b want 0 0 1 1 0",
                     vec_count, err_count, busy, in_ready, done);
        end
        tests_run++;
        if (ff_a !== '0 || ff_b !== '0 || ff_exp !== '0) begin
            tests_failed++;
            $display("FAIL restart_ff got a=%h b=%h exp=%h want 0", ff_a, ff_b, ff_exp);
        end
        drive_vec(4'h2, 4'h2, 1'b0, 5'h04, 1'b1);
        tick();
        quiet();
        tick();
    endtask

    task automatic test_hold_no_start();
        // In DONE with vec_count=1 from the restart run.
        in_valid = 1'b1;
        last     = 1'b1;
        repeat (5) tick();
        tests_run++;
        if (vec_count !== CNT_W'(1) || in_ready !== 1'b0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL done_hold got vec=%0d rdy=%b done=%b want 1 0 1", vec_count, in_ready, done);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        tests_run++;
        if (vec_count !== '0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_hold got vec=%0d rdy=%b busy=%b want 0 0 0", vec_count, in_ready, busy);
        end
        // start together with a last vector in IDLE: only the start counts.
        drive_vec(4'h1, 4'h2, 1'b0, 5'h03, 1'b1);
        start = 1'b1;
        tick();
        quiet();
        tick();
        tests_run++;
        if (busy !== 1'b1 || done !== 1'b0 || vec_count !== '0) begin
            tests_failed++;
            $display("FAIL start_with_valid got busy=%b done=%b vec=%0d want 1 0 0", busy, done, vec_count);
        end
    endtask

    task automatic test_reset_in_run();
        // Still in RUN from the previous task.
        for (int i = 0; i < 10; i++) begin
            drive_vec(4'(i), 4'h1, 1'b0, 5'(i + 1), 1'b0);
            tick();
        end
        tests_run++;
        if (vec_count !== CNT_W'(9)) begin
            tests_failed++;
            $display("FAIL run_partial got vec=%0d want 9", vec_count);
        end
        drive_vec(4'hf, 4'hf, 1'b1, 5'h00, 1'b1);
        start = 1'b1;
        rst   = 1'b1;
        tick();
        rst = 1'b0;
        quiet();
        tests_run++;
        if (vec_count !== '0 || err_count !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_in_run got vec=%0d err=%0d busy=%b rdy=%b want 0 0 0 0",
                     vec_count, err_count, busy, in_ready);
        end
        tick();
        tests_run++;
        if (vec_count !== '0 || err_count !== '0) begin
            tests_failed++;
            $display("FAIL rst_pipe_discard got vec=%0d err=%0d want 0 0", vec_count, err_count);
        end
        pulse_start();
        drive_vec(4'ha, 4'h5, 1'b1, 5'h10, 1'b1);
        tick();
        quiet();
        tick();
        tests_run++;
        if (vec_count !== CNT_W'(1) || err_count !== '0 || pass !== 1'b1) begin
            tests_failed++;
            $display("FAIL one_vec_run got vec=%0d err=%0d pass=%b want 1 0 1", vec_count, err_count, pass);
        end
    endtask

    initial begin
        test_reset();
        test_exhaustive();
        test_single_error();
        test_two_errors();
        test_restart_in_done();
        test_hold_no_start();
        test_reset_in_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
